// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int unsigned INT_DIGITS = 10;
   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned ACC_W      = INT_DIGITS * DIGIT_W;
   localparam int unsigned CNT_W      = 6;

   localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
   localparam logic [DIGIT_W-1:0] ADJ_INC    = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [DIGIT_W-1:0] adjusted
);

   // Input never exceeds 9, so the sum stays within 4 bits.
   always_comb begin
      adjusted = digit;
      if (digit >= ADJ_THRESH) begin
         adjusted = DIGIT_W'(digit + ADJ_INC);
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, start/done handshake,
// 32-bit binary in, 8 packed BCD digits plus an overflow flag out.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int unsigned BIN_W      = 32,
   parameter int unsigned OUT_DIGITS = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [BIN_W-1:0]              bin,
   output logic                          busy,
   output logic                          done,
   output logic [DIGIT_W*OUT_DIGITS-1:0] bcd,
   output logic                          ovf
);

   localparam int unsigned BCD_W = DIGIT_W * OUT_DIGITS;
   localparam int unsigned CAT_W = ACC_W + BIN_W;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [ACC_W-1:0]   acc, acc_nxt, acc_adj, acc_shift;
   logic [BIN_W-1:0]   shreg, shreg_nxt, shreg_shift;
   logic [CAT_W-1:0]   cat_shift;
   logic               busy_nxt, done_nxt, ovf_nxt;
   logic [BCD_W-1:0]   bcd_nxt;

   for (genvar d = 0; d < INT_DIGITS; d++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit    (acc[d*DIGIT_W +: DIGIT_W]),
         .adjusted (acc_adj[d*DIGIT_W +: DIGIT_W])
      );
   end

   // Adjust-then-shift of the concatenated {accumulator, binary copy}.
   assign cat_shift   = {acc_adj, shreg} << 1;
   assign acc_shift   = cat_shift[CAT_W-1:BIN_W];
   assign shreg_shift = cat_shift[BIN_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         acc   <= '0;
         shreg <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         bcd   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         acc   <= acc_nxt;
         shreg <= shreg_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         bcd   <= bcd_nxt;
         ovf   <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      acc_nxt   = acc;
      shreg_nxt = shreg;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      bcd_nxt   = bcd;
      ovf_nxt   = ovf;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_SHIFT;
               shreg_nxt = bin;
               acc_nxt   = '0;
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
            end
         end
         ST_SHIFT: begin
            acc_nxt   = acc_shift;
            shreg_nxt = shreg_shift;
            cnt_nxt   = CNT_W'(cnt + CNT_W'(1));
            if (cnt == LAST_ITER) begin
               state_nxt = ST_DONE;
               done_nxt  = 1'b1;
               bcd_nxt   = acc_shift[BCD_W-1:0];
               ovf_nxt   = |acc_shift[ACC_W-1:BCD_W];
            end
         end
         ST_DONE: begin
            // Back-to-back start is accepted here; otherwise return to idle.
            if (start) begin
               state_nxt = ST_SHIFT;
               shreg_nxt = bin;
               acc_nxt   = '0;
               cnt_nxt   = '0;
            end else begin
               state_nxt = ST_IDLE;
               busy_nxt  = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule
